// File: rtl/ysyx_22050710_pkg.sv
// Shared types and constants for the ysyx_22050710 fetch path.
package ysyx_22050710_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAr   = 2'd1,
    StR    = 2'd2
  } ifu_state_e;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] AXI_PROT_INST = 3'b100;

endpackage

// File: rtl/ysyx_22050710_ifu_ibuf.sv
// One-entry instruction line buffer: tag/valid/data with lookup, fill and fence clear.
module ysyx_22050710_ifu_ibuf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-4:0] lookup_tag_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] hit_data_o,
  input  logic              fill_en_i,
  input  logic [ADDR_W-4:0] fill_tag_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              fence_i
);

  logic              valid_q, valid_d;
  logic [ADDR_W-4:0] tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en_i) begin
      valid_d = 1'b1;
      tag_d   = fill_tag_i;
      data_d  = fill_data_i;
    end
    // Fence must win over a coincident fill so no pre-fence line survives.
    if (fence_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_o      = valid_q && (tag_q == lookup_tag_i);
  assign hit_data_o = data_q;

endmodule

// File: rtl/ysyx_22050710_ifu_axi_bridge.sv
// Fetch-port to AXI4-Lite read bridge, one outstanding request.
// Define IFU_IBUF_EN to add a one-entry line buffer in front of AXI.
module ysyx_22050710_ifu_axi_bridge
  import ysyx_22050710_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_inst_sram_en,
  input  logic [ADDR_W-1:0] i_inst_sram_addr,
  output logic [DATA_W-1:0] o_inst_sram_rdata,
  output logic              o_inst_sram_rvalid,
  output logic              o_inst_sram_busy,
  output logic              o_fetch_err,
  input  logic              i_fence_i,
  output logic [ADDR_W-1:0] o_araddr,
  output logic              o_arvalid,
  input  logic              i_arready,
  output logic [2:0]        o_arprot,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic [1:0]        i_rresp,
  input  logic              i_rvalid,
  output logic              o_rready
);

  ifu_state_e        state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;
  logic              fill_en;
  logic              ibuf_hit;
  logic [DATA_W-1:0] ibuf_data;

`ifdef IFU_IBUF_EN
  ysyx_22050710_ifu_ibuf #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ibuf (
    .clk_i       (i_clk),
    .rst_ni      (i_rst_n),
    .lookup_tag_i(i_inst_sram_addr[ADDR_W-1:3]),
    .hit_o       (ibuf_hit),
    .hit_data_o  (ibuf_data),
    .fill_en_i   (fill_en),
    .fill_tag_i  (araddr_q[ADDR_W-1:3]),
    .fill_data_i (i_rdata),
    .fence_i     (i_fence_i)
  );
`else
  logic unused_ibuf;
  assign unused_ibuf = i_fence_i ^ fill_en;
  assign ibuf_hit    = 1'b0;
  assign ibuf_data   = '0;
`endif

  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    fill_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_inst_sram_en) begin
          if (ibuf_hit) begin
            rvalid_d = 1'b1;
            rdata_d  = ibuf_data;
          end else begin
            araddr_d  = {i_inst_sram_addr[ADDR_W-1:3], 3'b000};
            arvalid_d = 1'b1;
            state_d   = StAr;
          end
        end
      end
      StAr: begin
        if (i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StR;
        end
      end
      StR: begin
        if (i_rvalid && rready_q) begin
          rdata_d  = i_rdata;
          rvalid_d = 1'b1;
          err_d    = (i_rresp != AXI_RESP_OKAY);
          fill_en  = (i_rresp == AXI_RESP_OKAY);
          rready_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      err_q     <= err_d;
    end
  end

  assign o_araddr           = araddr_q;
  assign o_arvalid          = arvalid_q;
  assign o_rready           = rready_q;
  assign o_arprot           = AXI_PROT_INST;
  assign o_inst_sram_rdata  = rdata_q;
  assign o_inst_sram_rvalid = rvalid_q;
  assign o_fetch_err        = err_q;
  assign o_inst_sram_busy   = (state_q != StIdle);

endmodule
